ula_div: RTL and testbench
==========================

ULA_DIV -- requirements
Module: ula_div

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width; only 8 is supported.
REQ-002 SHALL have port clock  input  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port A  input  8  unsigned dividend, sampled together with start.
REQ-006 SHALL have port B  input  8  unsigned divisor, sampled together with start.
REQ-007 SHALL have port busy  output  1  high while a division is in progress (state RUN).
REQ-008 SHALL have port done  output  1  one-cycle pulse; results are valid during this cycle.
REQ-009 SHALL have port quotient  output  8  unsigned quotient, registered.
REQ-010 SHALL have port remainder  output  8  unsigned remainder, registered.
REQ-011 SHALL have port zero  output  1  high when quotient equals 0, same zero-flag sense as the ALU.
REQ-012 SHALL have port div_zero  output  1  high when the latched divisor was 0.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 In IDLE with start=1 and B!=0, SHALL latch A and B, clear the iteration counter and the partial remainder, and move to RUN.
REQ-015 In IDLE with start=1 and B=0, SHALL move directly to DONE with quotient=8'hFF, remainder=A, div_zero=1.
REQ-016 In RUN, SHALL perform one restoring-division step per cycle: 9-bit partial remainder shifted left with the next dividend MSB; if it is >= B, subtract B and shift 1 into the quotient, else shift 0.
REQ-017 SHALL use a 4-bit iteration counter and perform exactly 8 RUN cycles, then move to DONE.
REQ-018 Latency SHALL be fixed: done is high exactly 9 cycles after the cycle in which start is sampled (8 for RUN plus 1), and 1 cycle after it when B=0.
REQ-019 DONE SHALL last exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-020 start SHALL be ignored in RUN and DONE; A and B changes after the sample SHALL NOT affect the result.
REQ-021 quotient, remainder, zero and div_zero SHALL update only on entry to DONE and SHALL hold until the next DONE or reset.
REQ-022 zero SHALL equal (quotient==0), evaluated on the final quotient; for B=0, zero SHALL be 0.
REQ-023 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.

Reset
REQ-024 reset=1 SHALL force IDLE, busy=0, done=0, quotient=0, remainder=0, zero=1, div_zero=0, counter=0 at the next clock edge.
REQ-025 reset asserted during RUN or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-026 reset SHALL take priority over start in the same cycle.

Structure
REQ-027 FSM state encodings and WIDTH SHALL live in the shared NanoRisc defines include, next to the ULAOp encodings.
REQ-028 One sub-module, div_step (purely combinational single restoring step), SHALL be instantiated once; there SHALL be no other sub-modules.

Verification
REQ-029 Test A=100, B=7, start for one cycle -> done 9 cycles later, quotient=14, remainder=2, zero=0, div_zero=0.
REQ-030 Test A=5, B=9 -> quotient=0, remainder=5, zero=1.
REQ-031 Test A=200, B=0 -> done the next cycle, quotient=8'hFF, remainder=200, div_zero=1, busy never high.
REQ-032 Test A=255, B=1, then A=255, B=255 back to back -> quotient=255, remainder=0, then quotient=1, remainder=0.
REQ-033 Test start pulsed again with A=9, B=3 during RUN -> ignored; first result delivered unchanged and only one done pulse.
REQ-034 Test reset asserted in the 4th RUN cycle -> IDLE next cycle, all outputs at reset values, no done pulse; a following start works normally.

Source files
------------

// File: rtl/ula_div_pkg.sv
// Shared NanoRisc defines: ULA operation codes, datapath width
// and the divider FSM state encodings.
package ula_div_pkg;

    localparam int ULA_WIDTH = 8;

    typedef enum logic [3:0] {
        ULA_ADD = 4'd0,
        ULA_SUB = 4'd1,
        ULA_AND = 4'd2,
        ULA_OR  = 4'd3,
        ULA_XOR = 4'd4,
        ULA_SLT = 4'd5,
        ULA_DIV = 4'd6
    } ula_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    localparam logic [3:0] DIV_STEPS = 4'd8;

endpackage

// File: rtl/ula_div_step.sv
// One restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_msb,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_div;
    logic [WIDTH:0] w_diff;

    // Remainder stays below the divisor, so the 9-bit shifted value
    // minus the divisor always fits back into WIDTH bits.
    assign w_shift = {i_rem, i_msb};
    assign w_div   = {1'b0, i_div};
    assign w_diff  = w_shift - w_div;
    assign o_qbit  = (w_shift >= w_div);
    assign o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/ula_div.sv
// Multi-cycle unsigned restoring divider for the NanoRisc ULA:
// fixed 8-step latency, divide-by-zero short-cut to DONE.
module ula_div
    import ula_div_pkg::*;
#(
    parameter int WIDTH = ULA_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             zero,
    output logic             div_zero
);

    div_state_t       r_state;
    div_state_t       w_next;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_rem;
    logic             w_qbit;
    logic [WIDTH-1:0] w_qnext;
    logic             w_last;
    logic             w_bzero;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem  (r_rem),
        .i_msb  (r_a[WIDTH-1]),
        .i_div  (r_b),
        .o_rem  (w_rem),
        .o_qbit (w_qbit)
    );

    assign w_qnext = {r_q[WIDTH-2:0], w_qbit};
    assign w_last  = (r_cnt == DIV_STEPS - 4'd1);
    assign w_bzero = (B == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_bzero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            quotient  <= '0;
            remainder <= '0;
            zero      <= 1'b1;
            div_zero  <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            if (w_bzero) begin
                quotient  <= '1;
                remainder <= A;
                zero      <= 1'b0;
                div_zero  <= 1'b1;
            end else begin
                r_a   <= A;
                r_b   <= B;
                r_cnt <= '0;
                r_rem <= '0;
                r_q   <= '0;
            end
        end else if (r_state == S_RUN) begin
            r_a   <= r_a << 1;
            r_rem <= w_rem;
            r_q   <= w_qnext;
            r_cnt <= r_cnt + 4'd1;
            if (w_last) begin
                quotient  <= w_qnext;
                remainder <= w_rem;
                zero      <= (w_qnext == '0);
                div_zero  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ula_div.sv
// Randomised self-checking bench for ula_div against an
// arithmetic reference (A/B, A%B, divide-by-zero rule).
module tb_ula_div;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       zero;
    logic       div_zero;

    int total;
    int bad;

    ula_div #(.WIDTH(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .zero      (zero),
        .div_zero  (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".busy"}, {31'd0, busy}, 0);
        chk({tag, ".done"}, {31'd0, done}, 0);
        chk({tag, ".q"}, {24'd0, quotient}, 0);
        chk({tag, ".r"}, {24'd0, remainder}, 0);
        chk({tag, ".zero"}, {31'd0, zero}, 1);
        chk({tag, ".dz"}, {31'd0, div_zero}, 0);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input bit glitch, input string tag);
        int exp_q, exp_r, exp_lat, exp_busy;
        int lat, dones, busy_cnt;
        logic [7:0] q_d, r_d;
        logic z_d, dz_d;
        exp_q    = (b == 0) ? 255 : int'(a) / int'(b);
        exp_r    = (b == 0) ? int'(a) : int'(a) % int'(b);
        exp_lat  = (b == 0) ? 1 : 9;
        exp_busy = (b == 0) ? 0 : 8;
        lat = 0; dones = 0; busy_cnt = 0;
        q_d = '0; r_d = '0; z_d = 1'b0; dz_d = 1'b0;
        @(negedge clock);
        start = 1'b1; A = a; B = b;
        for (int n = 1; n <= 14; n++) begin
            @(posedge clock);
            #1;
            if (n == 1) begin
                start = 1'b0;
                A = 8'($urandom);
                B = 8'($urandom);
            end
            if (glitch && n == 3) begin
                start = 1'b1; A = 8'd9; B = 8'd3;
            end
            if (glitch && n == 4) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                dones++;
                if (lat == 0) begin
                    lat = n;
                    q_d = quotient; r_d = remainder;
                    z_d = zero; dz_d = div_zero;
                end
            end
        end
        chk({tag, ".lat"}, lat, exp_lat);
        chk({tag, ".dones"}, dones, 1);
        chk({tag, ".busy"}, busy_cnt, exp_busy);
        chk({tag, ".q"}, {24'd0, q_d}, exp_q);
        chk({tag, ".r"}, {24'd0, r_d}, exp_r);
        chk({tag, ".zero"}, {31'd0, z_d}, (exp_q == 0 && b != 0) ? 1 : 0);
        chk({tag, ".dz"}, {31'd0, dz_d}, (b == 0) ? 1 : 0);
        chk({tag, ".qhold"}, {24'd0, quotient}, exp_q);
        chk({tag, ".rhold"}, {24'd0, remainder}, exp_r);
    endtask

    initial begin
        int dones;
        logic [7:0] ra, rb;
        total = 0; bad = 0;
        reset = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clock);
        #1;
        chk_reset_vals("rst");
        reset = 1'b0;

        run_op(8'd100, 8'd7, 1'b0, "d100_7");
        run_op(8'd5, 8'd9, 1'b0, "d5_9");
        run_op(8'd200, 8'd0, 1'b0, "d200_0");
        run_op(8'd255, 8'd1, 1'b0, "d255_1");
        run_op(8'd255, 8'd255, 1'b0, "d255_255");
        run_op(8'd100, 8'd7, 1'b1, "glitch");

        // reset in the 4th RUN cycle aborts the division
        @(negedge clock);
        start = 1'b1; A = 8'd100; B = 8'd7;
        dones = 0;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clock);
            #1;
            if (n == 1) start = 1'b0;
            if (n == 4) reset = 1'b1;
            if (done) dones++;
        end
        chk_reset_vals("abort");
        reset = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clock);
            #1;
            if (done || busy) dones++;
        end
        chk("abort.nodone", dones, 0);
        run_op(8'd9, 8'd3, 1'b0, "after_abort");

        // reset wins over start in the same cycle
        @(negedge clock);
        reset = 1'b1; start = 1'b1; A = 8'd50; B = 8'd0;
        @(posedge clock);
        #1;
        reset = 1'b0; start = 1'b0;
        chk_reset_vals("rst_prio");
        dones = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clock);
            #1;
            if (done || busy) dones++;
        end
        chk("rst_prio.idle", dones, 0);

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run_op(ra, rb, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
